seq_mult_ctrl: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 7 +
 rtl/rca_n.sv | 28 ++
 rtl/seq_mult_ctrl.sv | 114 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
//   mult_state_t : controller state encoding (IDLE, RUN, DONE)
package seq_mult_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mult_state_t;

endpackage : seq_mult_pkg

// File: rtl/rca_n.sv
// Parameterized combinational ripple-carry adder built from 1-bit full adders.
// Ports:
//   a, b   : WIDTH-bit addends
//   c_in   : carry into bit 0
//   s      : WIDTH-bit sum
//   c_out  : carry out of the MSB
module rca_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  logic [WIDTH:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign c_out = c[WIDTH];

endmodule : rca_n

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier. One WIDTH-bit ripple-carry
// adder is reused for WIDTH iterations to build a 2*WIDTH-bit product.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous, active-high; aborts any operation in progress
//   start   : request, only sampled in IDLE
//   a, b    : multiplicand / multiplier, latched when start is accepted
//   busy    : high while in RUN or DONE
//   done    : one-cycle pulse, product valid
//   product : last result, held until the next operation completes
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mult_state_t        state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   acc_q,     acc_d;
  logic [WIDTH-1:0]   mq_q,      mq_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   mq_nxt;

  // Partial product is selected by the multiplier LSB currently in mq.
  assign add_b = mq_q[0] ? mcand_q : '0;

  rca_n #(.WIDTH(WIDTH)) u_rca (
    .a     (acc_q),
    .b     (add_b),
    .c_in  (1'b0),
    .s     (sum),
    .c_out (cout)
  );

  // Shift {cout, sum, mq} right by one: the carry lands in acc's MSB so the
  // full-width partial sum is preserved, and sum[0] becomes a product bit.
  assign acc_nxt = {cout, sum[WIDTH-1:1]};
  assign mq_nxt  = {sum[0], mq_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          mq_d    = b;
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_nxt;
        mq_d    = mq_nxt;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d   = S_DONE;
          product_d = {acc_nxt, mq_nxt};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign product = product_q;

endmodule : seq_mult_ctrl

// File: tb/tb_seq_mult_ctrl.sv
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  a, b;
  logic        busy, done;
  logic [7:0]  product;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] product8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.WIDTH(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  seq_mult_ctrl #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset   (reset),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (product8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accept edge; counts edges until done is seen.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
  endtask

  task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [7:0] exp);
    int lat;
    start = 1'b1; a = av; b = bv;
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    wait_done(tag, lat);
    check({tag, "_prod"}, product, exp);
    tick();
    check({tag, "_pulse"}, {busy, done}, 2'b00);
  endtask

  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv);
    int lat;
    start8 = 1'b1; a8 = av; b8 = bv;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
    check("w8_lat", lat, 8);
    check("w8_prod", product8, av * bv);
    tick();
    check("w8_pulse", done8, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prod", product, 0);

    run_op("t1_3x5", 4'd3, 4'd5, 8'd15);
    run_op("t2_15x15", 4'd15, 4'd15, 8'd225);
    run_op("t3_0x13", 4'd0, 4'd13, 8'd0);
    run_op("t3_9x0", 4'd9, 4'd0, 8'd0);

    // Back-to-back with start held high; operands change during RUN.
    start = 1'b1; a = 4'd7; b = 4'd6;
    tick();
    a = 4'd2; b = 4'd11;
    check("t4_busy", busy, 1);
    wait_done("t4_first", lat);
    check("t4_first_prod", product, 42);
    tick();
    check("t4_idle_gap", busy, 0);
    tick();
    check("t4_reaccept", busy, 1);
    start = 1'b0;
    wait_done("t4_second", lat);
    check("t4_second_prod", product, 22);
    tick();
    check("t4_pulse", done, 0);

    // Reset in the middle of a run.
    start = 1'b1; a = 4'd12; b = 4'd10;
    tick();
    start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_prod", product, 0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (done) seen = 1'b1;
      tick();
    end
    check("t5_no_done", seen, 0);
    run_op("t5_4x4", 4'd4, 4'd4, 8'd16);

    // Full operand sweep at WIDTH=4.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op("sweep", 4'(i), 4'(j), 8'(i * j));
      end
    end

    // WIDTH=8 corners plus a random sample.
    run_op8(8'd255, 8'd255);
    run_op8(8'd0, 8'd200);
    run_op8(8'd128, 8'd2);
    for (int k = 0; k < 20; k++) begin
      run_op8(8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_mult_ctrl
